fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC, requests instructions from instruction memory over a req/gnt + rvalid handshake, and holds the fetched word for decode.
- Decode takes Op = instr[31:26] from the held word.
- On consume, applies the next-PC rule: PC+4, beq target, or j target.

---
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and fetches one word at a time from
// instruction memory over a req/gnt + rvalid handshake. It holds that word
// for decode and applies the next-PC rule when decode consumes it.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] sign_imm
);

  // A misaligned reset value is forced onto a word boundary, so every PC is aligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HAVE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;
  logic [31:0] branch_offset;
  logic        fetch_req;

  assign pc_out        = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = (state_q == HAVE);
  assign branch_offset = sign_imm << 2;
  // The request is held low while reset is asserted, even though the state is already FETCH.
  assign imem_req      = fetch_req & ~rst;

  // Next-PC selection for the held instruction: jump wins over branch, branch wins over sequential.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_offset;
    end
  end

  // FSM next-state logic. Memory responses are accepted only in WAIT, so a stale rvalid is discarded.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    fetch_req = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_req = 1'b1;
        if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = HAVE;
        end
      end
      HAVE: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State, PC and held-instruction registers, with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A transaction-level reference model
// tracks PC, the outstanding request and the held word, and it is compared
// against the DUT on every falling edge. Directed scenarios pin the model
// to hand-computed literal addresses. A randomized loop then exercises the
// handshakes and the next-PC rules.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        branch_taken;
  logic        jump;
  logic [31:0] sign_imm;

  int checks;
  int errors;
  logic check_en;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_pending;
  logic        m_valid;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .branch_taken (branch_taken),
    .jump         (jump),
    .sign_imm     (sign_imm)
  );

  // Free-running clock with a period of 10 time units.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic rbit();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  function automatic logic [31:0] rword();
    logic [31:0] r;
    r = $urandom;
    return r & 32'hFFFF_FFFC;
  endfunction

  // The architectural next-PC rule, written directly as arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                             input logic br, input logic jmp,
                                             input logic [31:0] imm);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (jmp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
    if (br)  return seq + imm * 32'd4;
    return seq;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h, expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: fetching until granted, waiting for the data, then holding it until consumed.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc      <= RESET_PC;
      m_instr   <= 32'h0000_0000;
      m_pending <= 1'b0;
      m_valid   <= 1'b0;
    end else if (m_valid) begin
      if (instr_ready) begin
        m_pc    <= model_next(m_pc, m_instr, branch_taken, jump, sign_imm);
        m_valid <= 1'b0;
      end
    end else if (m_pending) begin
      if (imem_rvalid) begin
        m_instr   <= imem_rdata;
        m_valid   <= 1'b1;
        m_pending <= 1'b0;
      end
    end else if (imem_gnt) begin
      m_pending <= 1'b1;
    end
  end

  // Compare process: every output is checked against the model on each falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, (~rst & ~m_pending & ~m_valid)});
      checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("pc_out", pc_out, m_pc);
      checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
      checkOutput("instr", instr, m_instr);
      checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    end
  end

  task automatic applyStimulus(input logic g, input logic rv, input logic [31:0] rd,
                               input logic rdy, input logic br, input logic jmp,
                               input logic [31:0] imm);
    imem_gnt     = g;
    imem_rvalid  = rv;
    imem_rdata   = rd;
    instr_ready  = rdy;
    branch_taken = br;
    jump         = jmp;
    sign_imm     = imm;
    @(posedge clk);
    #1;
  endtask

  // One full instruction: grant after gnt_dly cycles, data after rv_dly, consume after rdy_dly.
  task automatic doInstr(input int gnt_dly, input int rv_dly, input int rdy_dly,
                         input logic [31:0] word, input logic br, input logic jmp,
                         input logic [31:0] imm);
    for (int i = 0; i < gnt_dly; i++)
      applyStimulus(1'b0, rbit(), rword(), rbit(), rbit(), rbit(), $urandom);
    applyStimulus(1'b1, rbit(), rword(), rbit(), rbit(), rbit(), $urandom);
    for (int i = 0; i < rv_dly; i++)
      applyStimulus(rbit(), 1'b0, rword(), rbit(), rbit(), rbit(), $urandom);
    applyStimulus(rbit(), 1'b1, word, rbit(), rbit(), rbit(), $urandom);
    checkOutput("held_instr", instr, word);
    checkOutput("held_valid", {31'b0, instr_valid}, 32'd1);
    for (int i = 0; i < rdy_dly; i++)
      applyStimulus(rbit(), rbit(), rword(), 1'b0, rbit(), rbit(), $urandom);
    applyStimulus(rbit(), rbit(), rword(), 1'b1, br, jmp, imm);
  endtask

  // Pins both the DUT and the model to one hand-computed fetch address.
  task automatic checkAddr(input string name, input logic [31:0] expected);
    checkOutput(name, imem_addr, expected);
    checkOutput({name, "_model"}, m_pc, expected);
  endtask

  // Directed scenarios followed by a randomized run.
  initial begin
    checks       = 0;
    errors       = 0;
    check_en     = 1'b0;
    rst          = 1'b1;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    sign_imm     = 32'h0;

    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_req", {31'b0, imem_req}, 32'd0);
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("reset_pc", pc_out, 32'h0000_0000);
    rst = 1'b0;
    $display("[TB] reset released");

    // Sequential fetches at the minimum rate.
    doInstr(0, 0, 0, 32'h8C08_0004, 1'b0, 1'b0, 32'h0);
    checkAddr("seq_addr_4", 32'h0000_0004);
    doInstr(0, 0, 0, rword(), 1'b0, 1'b0, 32'h0);
    checkAddr("seq_addr_8", 32'h0000_0008);
    doInstr(0, 0, 0, rword(), 1'b0, 1'b0, 32'h0);
    checkAddr("seq_addr_c", 32'h0000_000C);
    doInstr(1, 2, 0, rword(), 1'b0, 1'b0, 32'h0);
    checkAddr("seq_addr_10", 32'h0000_0010);

    // Backward branch from 0x10, with grant and ready backpressure.
    doInstr(3, 1, 5, rword(), 1'b1, 1'b0, 32'hFFFF_FFFD);
    checkAddr("branch_back", 32'h0000_0008);

    // Far forward branch from 0x8 into the 0x1000_0000 region.
    doInstr(0, 0, 0, rword(), 1'b1, 1'b0, 32'h03FF_FFFD);
    checkAddr("branch_far", 32'h1000_0000);

    // A jump takes priority over a taken branch.
    doInstr(0, 0, 2, 32'h0800_0040, 1'b1, 1'b1, 32'h0000_0123);
    checkAddr("jump_prio", 32'h1000_0100);

    // Reset while waiting for data, then a stale response arrives in FETCH.
    applyStimulus(1'b1, 1'b0, rword(), 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("midrst_pc", pc_out, RESET_PC);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEC, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEC, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("stale_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("stale_req", {31'b0, imem_req}, 32'd1);
    checkAddr("stale_addr", RESET_PC);

    // Wrap-around of the PC at the top of the address space.
    doInstr(0, 0, 0, rword(), 1'b1, 1'b0, 32'hFFFF_FFFE);
    checkAddr("wrap_top", 32'hFFFF_FFFC);
    doInstr(0, 1, 0, rword(), 1'b0, 1'b0, 32'h0);
    checkAddr("wrap_zero", 32'h0000_0000);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 150; n++) begin
      doInstr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rword(),
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), $urandom);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
